// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU configuration: ROB sizing, CDB source encoding, no-jump target.
package cdb_arbiter_pkg;

    localparam int unsigned CFG_ROB_LOG  = 4;
    localparam int unsigned CFG_ROB_SIZE = 1 << CFG_ROB_LOG;

    // Branch target meaning "not taken"; shared with the ALU and ROB.
    localparam logic [31:0] NO_JUMP = '1;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

    function automatic cdb_src_e other_src(input cdb_src_e s);
        return (s == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
    endfunction

endpackage

// File: rtl/cdb_queue.sv
// Small per-producer result FIFO feeding the CDB arbiter.
module cdb_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     rdy,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot for this cycle's push.
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[head_ptr];

    // Storage write at tail; no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (!clear && rdy && do_push) begin
            mem[tail_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (rdy) begin
            if (do_push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (do_pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between the ALU and LSB load path.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned ROB_LOG     = CFG_ROB_LOG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush,
    input  logic               alu_valid,
    input  logic [31:0]        alu_value,
    input  logic [31:0]        alu_toPC,
    input  logic [ROB_LOG-1:0] alu_RobId,
    output logic               alu_full,
    input  logic               lsb_valid,
    input  logic [31:0]        lsb_value,
    input  logic [ROB_LOG-1:0] lsb_RobId,
    output logic               lsb_full,
    output logic               cdb_valid,
    output logic               cdb_src,
    output logic [31:0]        cdb_value,
    output logic [31:0]        cdb_toPC,
    output logic [ROB_LOG-1:0] cdb_RobId
);

    localparam int unsigned ALU_W = 64 + ROB_LOG;
    localparam int unsigned LSB_W = 32 + ROB_LOG;
    localparam int unsigned CW    = $clog2(QUEUE_DEPTH) + 1;

    logic               clear;
    logic [ALU_W-1:0]   alu_head;
    logic [LSB_W-1:0]   lsb_head;
    logic               alu_empty;
    logic               lsb_empty;
    logic [CW-1:0]      alu_count;
    logic [CW-1:0]      lsb_count;
    logic               alu_pop;
    logic               lsb_pop;
    logic               grant_valid;
    logic               conflict;
    cdb_src_e           grant_src;
    cdb_src_e           last_grant;
    logic               unused_counts;

    logic [31:0]        alu_head_value;
    logic [31:0]        alu_head_toPC;
    logic [ROB_LOG-1:0] alu_head_RobId;
    logic [31:0]        lsb_head_value;
    logic [ROB_LOG-1:0] lsb_head_RobId;

    assign clear = rst | flush;

    cdb_queue #(
        .WIDTH (ALU_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_alu_queue (
        .clk       (clk),
        .clear     (clear),
        .rdy       (rdy),
        .push      (alu_valid),
        .push_data ({alu_value, alu_toPC, alu_RobId}),
        .pop       (alu_pop),
        .head      (alu_head),
        .empty     (alu_empty),
        .full      (alu_full),
        .count     (alu_count)
    );

    cdb_queue #(
        .WIDTH (LSB_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_lsb_queue (
        .clk       (clk),
        .clear     (clear),
        .rdy       (rdy),
        .push      (lsb_valid),
        .push_data ({lsb_value, lsb_RobId}),
        .pop       (lsb_pop),
        .head      (lsb_head),
        .empty     (lsb_empty),
        .full      (lsb_full),
        .count     (lsb_count)
    );

    assign unused_counts = ^{alu_count, lsb_count};

    assign {alu_head_value, alu_head_toPC, alu_head_RobId} = alu_head;
    assign {lsb_head_value, lsb_head_RobId}                = lsb_head;

    // Pick a source from the queue heads; alternate only when both are waiting.
    always_comb begin
        grant_valid = 1'b0;
        conflict    = 1'b0;
        grant_src   = CDB_SRC_ALU;
        if (!alu_empty && !lsb_empty) begin
            grant_valid = 1'b1;
            conflict    = 1'b1;
            grant_src   = other_src(last_grant);
        end else if (!alu_empty) begin
            grant_valid = 1'b1;
            grant_src   = CDB_SRC_ALU;
        end else if (!lsb_empty) begin
            grant_valid = 1'b1;
            grant_src   = CDB_SRC_LSB;
        end
    end

    assign alu_pop = grant_valid && (grant_src == CDB_SRC_ALU);
    assign lsb_pop = grant_valid && (grant_src == CDB_SRC_LSB);

    // Register the granted head onto the bus and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid  <= 1'b0;
            cdb_src    <= CDB_SRC_ALU;
            cdb_value  <= '0;
            cdb_toPC   <= NO_JUMP;
            cdb_RobId  <= '0;
            last_grant <= CDB_SRC_LSB;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (rdy) begin
            cdb_valid <= grant_valid;
            if (grant_valid) begin
                cdb_src <= grant_src;
                if (grant_src == CDB_SRC_ALU) begin
                    cdb_value <= alu_head_value;
                    cdb_toPC  <= alu_head_toPC;
                    cdb_RobId <= alu_head_RobId;
                end else begin
                    cdb_value <= lsb_head_value;
                    cdb_toPC  <= NO_JUMP;
                    cdb_RobId <= lsb_head_RobId;
                end
            end
            if (conflict) begin
                last_grant <= grant_src;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter.
module tb_cdb_arbiter;

    localparam logic [31:0] NJ = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        alu_valid;
    logic [31:0] alu_value;
    logic [31:0] alu_toPC;
    logic [3:0]  alu_RobId;
    logic        alu_full;
    logic        lsb_valid;
    logic [31:0] lsb_value;
    logic [3:0]  lsb_RobId;
    logic        lsb_full;
    logic        cdb_valid;
    logic        cdb_src;
    logic [31:0] cdb_value;
    logic [31:0] cdb_toPC;
    logic [3:0]  cdb_RobId;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst, rdy, flush;
        logic        av;
        logic [31:0] aval, apc;
        logic [3:0]  aid;
        logic        lv;
        logic [31:0] lval;
        logic [3:0]  lid;
        logic        ev, esrc;
        logic [31:0] eval, epc;
        logic [3:0]  eid;
        logic        eaf, elf;
    } vec_t;

    vec_t vecs[$];

    cdb_arbiter #(
        .QUEUE_DEPTH (4),
        .ROB_LOG     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_value (alu_value),
        .alu_toPC  (alu_toPC),
        .alu_RobId (alu_RobId),
        .alu_full  (alu_full),
        .lsb_valid (lsb_valid),
        .lsb_value (lsb_value),
        .lsb_RobId (lsb_RobId),
        .lsb_full  (lsb_full),
        .cdb_valid (cdb_valid),
        .cdb_src   (cdb_src),
        .cdb_value (cdb_value),
        .cdb_toPC  (cdb_toPC),
        .cdb_RobId (cdb_RobId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t r(
        input logic [31:0] rst_i, rdy_i, flush_i,
        input logic [31:0] av, aval, apc, aid,
        input logic [31:0] lv, lval, lid,
        input logic [31:0] ev, esrc, eval, epc, eid,
        input logic [31:0] eaf, elf);
        vec_t v;
        v.rst = rst_i[0]; v.rdy = rdy_i[0]; v.flush = flush_i[0];
        v.av = av[0]; v.aval = aval; v.apc = apc; v.aid = aid[3:0];
        v.lv = lv[0]; v.lval = lval; v.lid = lid[3:0];
        v.ev = ev[0]; v.esrc = esrc[0]; v.eval = eval; v.epc = epc; v.eid = eid[3:0];
        v.eaf = eaf[0]; v.elf = elf[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        rst = v.rst; rdy = v.rdy; flush = v.flush;
        alu_valid = v.av; alu_value = v.aval; alu_toPC = v.apc; alu_RobId = v.aid;
        lsb_valid = v.lv; lsb_value = v.lval; lsb_RobId = v.lid;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d cdb_valid", idx), 32'(cdb_valid), 32'(v.ev));
        if (v.ev) begin
            check($sformatf("vec%0d cdb_src", idx), 32'(cdb_src), 32'(v.esrc));
            check($sformatf("vec%0d cdb_value", idx), cdb_value, v.eval);
            check($sformatf("vec%0d cdb_toPC", idx), cdb_toPC, v.epc);
            check($sformatf("vec%0d cdb_RobId", idx), 32'(cdb_RobId), 32'(v.eid));
        end
        check($sformatf("vec%0d alu_full", idx), 32'(alu_full), 32'(v.eaf));
        check($sformatf("vec%0d lsb_full", idx), 32'(lsb_full), 32'(v.elf));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        alu_valid = 1'b0; alu_value = '0; alu_toPC = '0; alu_RobId = '0;
        lsb_valid = 1'b0; lsb_value = '0; lsb_RobId = '0;

        // Single ALU push, 2-cycle latency
        vecs.push_back(r(0,1,0, 1,'h11,NJ,3,    0,0,0,      0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,0,'h11,NJ,3,      0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      0,0,0,0,0,          0,0));
        // Conflict fairness: A0 B0 A1 B1 A2 B2
        vecs.push_back(r(0,1,0, 1,'hA0,'h100,1, 1,'hB0,4,   0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 1,'hA1,'h101,2, 1,'hB1,5,   1,0,'hA0,'h100,1,   0,0));
        vecs.push_back(r(0,1,0, 1,'hA2,'h102,3, 1,'hB2,6,   1,1,'hB0,NJ,4,      0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,0,'hA1,'h101,2,   0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,1,'hB1,NJ,5,      0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,0,'hA2,'h102,3,   0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,1,'hB2,NJ,6,      0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      0,0,0,0,0,          0,0));
        // Stall with id 7 on the bus; push during stall is ignored
        vecs.push_back(r(0,1,0, 0,0,0,0,        1,'h77,7,   0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        1,'h88,8,   1,1,'h77,NJ,7,      0,0));
        vecs.push_back(r(0,0,0, 0,0,0,0,        1,'h99,9,   1,1,'h77,NJ,7,      0,0));
        vecs.push_back(r(0,0,0, 0,0,0,0,        0,0,0,      1,1,'h77,NJ,7,      0,0));
        vecs.push_back(r(0,0,0, 0,0,0,0,        0,0,0,      1,1,'h77,NJ,7,      0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,1,'h88,NJ,8,      0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      0,0,0,0,0,          0,0));
        // Reset, then fill the ALU FIFO while it loses every other cycle
        vecs.push_back(r(1,1,0, 0,0,0,0,        0,0,0,      0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 1,'hC0,'h200,0, 1,'hD0,8,   0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 1,'hC1,'h201,1, 1,'hD1,9,   1,0,'hC0,'h200,0,   0,0));
        vecs.push_back(r(0,1,0, 1,'hC2,'h202,2, 0,0,0,      1,1,'hD0,NJ,8,      0,0));
        vecs.push_back(r(0,1,0, 1,'hC3,'h203,3, 1,'hD2,10,  1,0,'hC1,'h201,1,   0,0));
        vecs.push_back(r(0,1,0, 1,'hC4,'h204,4, 0,0,0,      1,1,'hD1,NJ,9,      0,0));
        vecs.push_back(r(0,1,0, 1,'hC5,'h205,5, 1,'hD3,11,  1,0,'hC2,'h202,2,   0,0));
        vecs.push_back(r(0,1,0, 1,'hC6,'h206,6, 0,0,0,      1,1,'hD2,NJ,10,     1,0));
        vecs.push_back(r(0,0,0, 1,'hC7,'h207,7, 0,0,0,      1,1,'hD2,NJ,10,     1,0));
        vecs.push_back(r(0,0,0, 1,'hC7,'h207,7, 0,0,0,      1,1,'hD2,NJ,10,     1,0));
        vecs.push_back(r(0,1,0, 1,'hC7,'h207,7, 0,0,0,      1,0,'hC3,'h203,3,   0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,1,'hD3,NJ,11,     0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,0,'hC4,'h204,4,   0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,0,'hC5,'h205,5,   0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,0,'hC6,'h206,6,   0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      0,0,0,0,0,          0,0));
        // Flush with three LSB entries queued and an ALU result on the bus
        vecs.push_back(r(0,1,0, 1,'h50,'h300,1, 1,'hE0,9,   0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 1,'h51,'h301,2, 1,'hE1,10,  1,0,'h50,'h300,1,   0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        1,'hE2,11,  1,1,'hE0,NJ,9,      0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        1,'hE3,12,  1,0,'h51,'h301,2,   0,0));
        vecs.push_back(r(0,1,1, 1,'h5F,'h2FF,5, 0,0,0,      0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        1,'hE9,13,  0,0,0,0,0,          0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      1,1,'hE9,NJ,13,     0,0));
        vecs.push_back(r(0,1,0, 0,0,0,0,        0,0,0,      0,0,0,0,0,          0,0));

        repeat (2) @(posedge clk);
        #1;
        check("reset cdb_valid", 32'(cdb_valid), 32'd0);
        check("reset cdb_src", 32'(cdb_src), 32'd0);
        check("reset cdb_value", cdb_value, 32'd0);
        check("reset cdb_toPC", cdb_toPC, NJ);
        check("reset cdb_RobId", 32'(cdb_RobId), 32'd0);
        check("reset alu_full", 32'(alu_full), 32'd0);
        check("reset lsb_full", 32'(lsb_full), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // LSB-only stream of ten ids through the depth-4 queue (pointers wrap twice)
        alu_valid = 1'b0; flush = 1'b0; rdy = 1'b1; rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            lsb_valid = (i < 10);
            lsb_value = 32'h400 + 32'(i);
            lsb_RobId = 4'(i);
            @(posedge clk);
            #1;
            if (i == 0 || i == 11) begin
                check($sformatf("wrap%0d cdb_valid", i), 32'(cdb_valid), 32'd0);
            end else begin
                check($sformatf("wrap%0d cdb_valid", i), 32'(cdb_valid), 32'd1);
                check($sformatf("wrap%0d cdb_src", i), 32'(cdb_src), 32'd1);
                check($sformatf("wrap%0d cdb_value", i), cdb_value, 32'h400 + 32'(i - 1));
                check($sformatf("wrap%0d cdb_toPC", i), cdb_toPC, NJ);
                check($sformatf("wrap%0d cdb_RobId", i), 32'(cdb_RobId), 32'(i - 1));
            end
            check($sformatf("wrap%0d lsb_full", i), 32'(lsb_full), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
